// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequences IDLE/FETCH/HOLD, holds one instruction
// for the control unit and computes the next PC when it is retired.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func_code,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        instr_ack,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        addr_err,
    output logic [31:0] retired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_instr_valid;
    logic        r_addr_err;
    logic [31:0] r_retired;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;
    logic        w_fetch_done;
    logic        w_ack;

    // Handshakes only count in the state that owns them; stray pulses elsewhere are ignored.
    assign w_fetch_done = (r_state == S_FETCH) && imem_ready;
    assign w_ack        = (r_state == S_HOLD) && instr_ack;

    // Link value and branch offset derive from the held instruction; all sums wrap mod 2^32.
    assign w_pc_plus4 = r_pc_out + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Next-PC select: JR beats jump beats taken branch beats sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jr)
            w_next_pc = {jr_target[31:2], 2'b00};
        else if (jump)
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        else if (branch_taken)
            w_next_pc = w_pc_plus4 + w_br_off;
    end

    // FSM and architectural state; reset abandons any in-flight fetch or held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_pc_out      <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_addr_err    <= 1'b0;
            r_retired     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_fetch_done) begin
                        r_instr       <= imem_rdata;
                        r_pc_out      <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_ack) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_retired     <= r_retired + 32'd1;
                        r_state       <= S_FETCH;
                        if (jr && (jr_target[1:0] != 2'b00))
                            r_addr_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign func_code   = r_instr[5:0];
    assign pc_out      = r_pc_out;
    assign pc_plus4    = w_pc_plus4;
    assign addr_err    = r_addr_err;
    assign retired     = r_retired;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset; SHALL be word-aligned.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address; SHALL equal pc.
REQ-006 imem_ready  input  1  imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr_valid  output  1  instr/op/func_code/pc_out valid for the control unit.
REQ-009 instr  output  32  registered instruction.
REQ-010 op  output  6  instr[31:26], to control unit Op.
REQ-011 func_code  output  6  instr[5:0], to control unit FuncCode.
REQ-012 pc_out  output  32  address of the held instruction.
REQ-013 pc_plus4  output  32  pc_out+4 (JAL link value).
REQ-014 instr_ack  input  1  execute stage retired the held instruction; resolution inputs valid this cycle.
REQ-015 branch_taken  input  1  conditional branch resolved taken.
REQ-016 jump  input  1  JA/JAL.
REQ-017 jr  input  1  register jump (JR).
REQ-018 jr_target  input  32  register value for JR.
REQ-019 addr_err  output  1  sticky misaligned-JR flag.
REQ-020 retired  output  32  count of acknowledged instructions.

Function
REQ-021 States SHALL be IDLE, FETCH, HOLD.
REQ-022 IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-023 FETCH: imem_req=1, imem_addr=pc held stable; stays in FETCH while imem_ready=0.
REQ-024 FETCH with imem_ready=1: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, next state HOLD; instr_valid is high the cycle after imem_ready (1-cycle latency).
REQ-025 HOLD: imem_req=0; instr, op, func_code, pc_out held constant while instr_ack=0.
REQ-026 HOLD with instr_ack=1: pc<=next_pc, instr_valid<=0, retired<=retired+1, next state FETCH; imem_req rises the cycle after ack.
REQ-027 next_pc priority: jr -> {jr_target[31:2],2'b00}; else jump -> {pc_plus4[31:28],instr[25:0],2'b00}; else branch_taken -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-028 Multiple of jr/jump/branch_taken asserted together SHALL resolve by REQ-027 priority with no error.
REQ-029 All PC arithmetic modulo 2^32: pc_out=32'hFFFF_FFFC gives pc_plus4=0; negative branch offsets wrap likewise.
REQ-030 jr=1 with instr_ack=1 and jr_target[1:0]!=0 SHALL set addr_err=1; it stays set until reset.
REQ-031 instr_ack, imem_ready outside HOLD, FETCH respectively SHALL be ignored.
REQ-032 retired wraps 32'hFFFF_FFFF -> 0.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, pc_out=RESET_PC, addr_err=0, retired=0.
REQ-034 Reset asserted during FETCH or HOLD SHALL abandon the pending fetch/instruction; first request after release is to RESET_PC.

Verification
REQ-035 Reset release, imem_ready in 2nd FETCH cycle with 32'h0000_0020 -> imem_req high 1 cycle after release, instr_valid next cycle, op=0, func_code=6'h20, pc_out=0.
REQ-036 Held instr at pc 0x100, low16=16'hFFFE, branch_taken+ack -> next imem_addr=0xFC; retired increments by 1.
REQ-037 Held instr at 0x4000_0010, instr[25:0]=26'h10, jump+branch_taken+ack -> imem_addr=0x4000_0040.
REQ-038 jr+ack, jr_target=0x0000_1236 -> imem_addr=0x1234, addr_err=1 and stays 1 through later fetches.
REQ-039 imem_ready held 0 for 5 cycles -> imem_addr stable, instr_valid 0; instr_ack pulsed in FETCH has no effect.
REQ-040 rst_n asserted mid-HOLD -> instr_valid=0 same cycle; after release fetch restarts at RESET_PC, retired=0.
